// File: rtl/load_store_unit.sv
// RV32I memory stage: one load or store per request over a req/ready data bus.
// Optional LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses fault without touching the bus.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned ADDR_WIDTH     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic                  i_is_store,
   input  logic [2:0]            i_funct3,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [31:0]           i_store_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [31:0]           o_load_data,
   output logic                  o_misaligned,
   output logic                  o_bus_error,
   output logic                  o_mem_req,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [3:0]            o_mem_wstrb,
   output logic [31:0]           o_mem_wdata,
   input  logic                  i_mem_ready,
   input  logic [31:0]           i_mem_rdata
);

   localparam int unsigned CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_is_store;
   logic [2:0]       r_funct3;
   logic [1:0]       r_off;
   logic             r_fault;
   logic [CNT_W-1:0] r_cnt;

   logic        w_is_byte;
   logic        w_is_half;
   logic [1:0]  w_off;
   logic        w_misaligned;
   logic [3:0]  w_wstrb;
   logic [31:0] w_wdata;
   logic [31:0] w_shifted;
   logic [31:0] w_load;
   logic        w_timeout;

   // Request decode: lane offset, replicated write data and byte strobes.
   always_comb begin
      w_is_byte = (i_funct3[1:0] == 2'b00);
      w_is_half = (i_funct3[1:0] == 2'b01);
      w_off     = 2'b00;
      w_wstrb   = 4'b1111;
      w_wdata   = i_store_data;
      if (w_is_byte) begin
         w_off   = i_addr[1:0];
         w_wstrb = 4'(4'b0001 << w_off);
         w_wdata = {4{i_store_data[7:0]}};
      end else if (w_is_half) begin
         w_off   = {i_addr[1], 1'b0};
         w_wstrb = 4'(4'b0011 << w_off);
         w_wdata = {2{i_store_data[15:0]}};
      end
`ifdef LSU_MISALIGN_TRAP_EN
      w_misaligned = (w_is_half && i_addr[0]) ||
                     (!w_is_byte && !w_is_half && (i_addr[1:0] != 2'b00));
`else
      w_misaligned = 1'b0;
`endif
   end

   // Load extraction from the latched width code and lane offset.
   always_comb begin
      w_shifted = i_mem_rdata >> {r_off, 3'b000};
      w_load    = i_mem_rdata;
      if (r_funct3[1:0] == 2'b00) begin
         w_load = {{24{~r_funct3[2] & w_shifted[7]}}, w_shifted[7:0]};
      end else if (r_funct3[1:0] == 2'b01) begin
         w_load = {{16{~r_funct3[2] & w_shifted[15]}}, w_shifted[15:0]};
      end
   end

   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TO_LAST));

   // Control FSM; every output is a register written here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_is_store   <= 1'b0;
         r_funct3     <= 3'b000;
         r_off        <= 2'b00;
         r_fault      <= 1'b0;
         r_cnt        <= '0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_load_data  <= 32'h0;
         o_misaligned <= 1'b0;
         o_bus_error  <= 1'b0;
         o_mem_req    <= 1'b0;
         o_mem_we     <= 1'b0;
         o_mem_addr   <= '0;
         o_mem_wstrb  <= 4'b0000;
         o_mem_wdata  <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_is_store   <= i_is_store;
                  r_funct3     <= i_funct3;
                  r_off        <= w_off;
                  r_cnt        <= '0;
                  o_busy       <= 1'b1;
                  o_misaligned <= w_misaligned;
                  o_bus_error  <= 1'b0;
                  o_load_data  <= 32'h0;
                  o_mem_addr   <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
                  o_mem_wstrb  <= i_is_store ? w_wstrb : 4'b0000;
                  o_mem_wdata  <= i_is_store ? w_wdata : 32'h0;
                  if (w_misaligned) begin
                     // Fault path spends one holding cycle so done keeps the 2-cycle latency.
                     r_fault <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     o_mem_req <= 1'b1;
                     o_mem_we  <= i_is_store;
                     r_state   <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               if (i_mem_ready) begin
                  if (!r_is_store) begin
                     o_load_data <= w_load;
                  end
                  o_mem_req <= 1'b0;
                  o_mem_we  <= 1'b0;
                  o_busy    <= 1'b0;
                  o_done    <= 1'b1;
                  r_state   <= S_DONE;
               end else if (w_timeout) begin
                  o_mem_req   <= 1'b0;
                  o_mem_we    <= 1'b0;
                  o_bus_error <= 1'b1;
                  o_busy      <= 1'b0;
                  o_done      <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (r_fault) begin
                  r_fault <= 1'b0;
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
               end else begin
                  o_done  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
